mem_array: RTL and testbench

Parametrised synchronous word memory: DEPTH words of WIDTH bits each, with a registered read port and a background bulk-clear engine. It is the clocked, width- and depth-generic successor to the single storage cell and the fixed 8x8 array. It adds asynchronous reset, read-valid signalling, defined read-during-write behaviour and a runtime clear sequencer. It sits between the datapath/controller and the storage, one access per clock.

---
 rtl/mem_array.sv | 59 +++++
 tb/tb_mem_array.sv | 114 +++++++++++
 2 files changed

// File: rtl/mem_array.sv
// mem_array: parametrised word memory with registered read port and background bulk-clear engine
module mem_array #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  din,
   input  logic              we,
   input  logic              re,
   output logic [WIDTH-1:0]  dout,
   output logic              rd_valid,
   output logic              addr_err,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_done
);
   typedef enum logic {IDLE, CLEAR} state_t;
   localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);
   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic              in_range, acc, wr_en, rd_en, err, last;
   always_comb begin
      in_range  = {1'b0, addr} < DEPTH_W;
      last      = ptr == LAST;
      acc       = state == IDLE && !clr_req;
      wr_en     = acc && we && in_range;
      rd_en     = acc && re && in_range;
      err       = acc && (we || re) && !in_range;
      state_nxt = state == IDLE ? (clr_req ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
      ptr_nxt   = state == IDLE ? '0 : ptr + 1'b1;
   end
   assign busy = state == CLEAR;
   // Nonblocking read before write gives read-first behaviour on a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         dout     <= '0;
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
         clr_done <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         rd_valid <= rd_en;
         addr_err <= err;
         clr_done <= state == CLEAR && last;
         if (rd_en) dout <= mem[addr];
         if (state == CLEAR) mem[ptr] <= '0;
         else if (wr_en) mem[addr] <= din;
      end
   end
endmodule

// File: tb/tb_mem_array.sv
// tb_mem_array: randomized and directed checks of mem_array against a countdown-based reference model
module tb_mem_array;
   localparam int W = 8, D = 6, AW = 3;
   logic clk = 0, rst_n = 1, we = 0, re = 0, clr_req = 0;
   logic [AW-1:0] addr = '0;
   logic [W-1:0]  din = '0;
   logic [W-1:0]  dout;
   logic rd_valid, addr_err, busy, clr_done;
   int n_tests = 0, n_fail = 0;
   logic [W-1:0] mdl [D];
   int clr_left = 0;
   logic [W-1:0] e_dout = '0;
   logic e_valid = 0, e_err = 0, e_done = 0;

   mem_array #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .we(we), .re(re),
      .dout(dout), .rd_valid(rd_valid), .addr_err(addr_err),
      .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic w, input logic r, input logic c, input int a, input logic [W-1:0] d);
      @(negedge clk);
      we = w; re = r; clr_req = c; addr = AW'(a); din = d;
      @(posedge clk);
      #1;
      e_valid = 0; e_err = 0; e_done = 0;
      if (clr_left > 0) begin
         mdl[D-clr_left] = '0;
         clr_left--;
         e_done = clr_left == 0;
      end else if (c) begin
         clr_left = D;
      end else if (a < D) begin
         if (r) begin e_dout = mdl[a]; e_valid = 1; end
         if (w) mdl[a] = d;
      end else if (w || r) begin
         e_err = 1;
      end
      chk("dout", 32'(dout), 32'(e_dout));
      chk("rd_valid", 32'(rd_valid), 32'(e_valid));
      chk("addr_err", 32'(addr_err), 32'(e_err));
      chk("busy", 32'(busy), 32'(clr_left > 0));
      chk("clr_done", 32'(clr_done), 32'(e_done));
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      for (int i = 0; i < D; i++) mdl[i] = '0;
      clr_left = 0; e_dout = '0;
      chk("rst_dout", 32'(dout), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_addr_err", 32'(addr_err), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_clr_done", 32'(clr_done), 0);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic fill(input logic [W-1:0] v);
      for (int i = 0; i < D; i++) step(1, 0, 0, i, v);
   endtask

   task automatic read_all();
      for (int i = 0; i < 8; i++) step(0, 1, 0, i, 8'h00);
   endtask

   initial begin
      do_reset();
      read_all();
      step(1, 0, 0, 3, 8'hA5);
      step(1, 0, 0, 5, 8'h5A);
      step(0, 1, 0, 3, 8'h00);
      step(0, 1, 0, 5, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      step(1, 0, 0, 2, 8'h11);
      step(1, 1, 0, 2, 8'h22);
      step(0, 1, 0, 2, 8'h00);
      step(1, 0, 0, 6, 8'hFF);
      step(0, 1, 0, 6, 8'h00);
      step(0, 1, 0, 5, 8'h00);
      step(1, 1, 0, 7, 8'h33);
      fill(8'hFF);
      step(1, 0, 1, 0, 8'h77);
      for (int i = 0; i < D + 1; i++) step(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)), 8'($urandom));
      read_all();
      fill(8'hC3);
      step(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < 3; i++) step(0, 1, 0, i, 8'h00);
      do_reset();
      read_all();
      fill(8'h3C);
      step(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < D + 1; i++) step(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < D; i++) step(0, 0, 0, 0, 8'h00);
      read_all();
      for (int i = 0; i < 400; i++)
         step(1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0, int'($urandom_range(0, 7)), 8'($urandom));
      read_all();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
